// File: rtl/aes_puf_sequencer.sv
// aes_puf_sequencer: clocked sequencer that holds an AES core in reset until a
// stable PUF key is available, feeds it one plaintext block at a time over a
// valid/ready handshake, and returns the ciphertext over a second handshake.
// A RUN-state watchdog raises a sticky error if the core never completes.
module aes_puf_sequencer #(
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [127:0]     key_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             aes_reset,
    output logic [127:0]     aes_data,
    output logic [127:0]     aes_key,
    input  logic             aes_done,
    input  logic [127:0]     aes_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             err,
    input  logic             err_clear,
    output logic [CNT_W-1:0] blk_count
);

    localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        WAIT_KEY = 3'd0,
        IDLE     = 3'd1,
        LOAD     = 3'd2,
        RUN      = 3'd3,
        OUT      = 3'd4,
        ERR      = 3'd5
    } state_t;

    state_t             state_q,     state_d;
    logic               in_ready_q,  in_ready_d;
    logic               aes_reset_q, aes_reset_d;
    logic [127:0]       aes_data_q,  aes_data_d;
    logic [127:0]       aes_key_q,   aes_key_d;
    logic               out_valid_q, out_valid_d;
    logic [127:0]       out_data_q,  out_data_d;
    logic               err_q,       err_d;
    logic [CNT_W-1:0]   blk_count_q, blk_count_d;
    logic [RC_W-1:0]    rst_cnt_q,   rst_cnt_d;
    logic [TO_W-1:0]    to_cnt_q,    to_cnt_d;

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        aes_reset_d = aes_reset_q;
        aes_data_d  = aes_data_q;
        aes_key_d   = aes_key_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        blk_count_d = blk_count_q;
        rst_cnt_d   = rst_cnt_q;
        to_cnt_d    = to_cnt_q;

        case (state_q)
            WAIT_KEY: begin
                aes_reset_d = 1'b1;
                if (key_valid) begin
                    aes_key_d = key_in;
                    state_d   = IDLE;
                end
            end

            IDLE: begin
                // Losing the key takes priority over a pending handshake, so a
                // block is never accepted against a key that just went away.
                if (!key_valid) begin
                    aes_key_d = '0;
                    state_d   = WAIT_KEY;
                end else if (in_valid && in_ready_q) begin
                    aes_data_d = in_data;
                    rst_cnt_d  = RC_W'(RST_CYCLES);
                    state_d    = LOAD;
                end
            end

            LOAD: begin
                // aes_reset is already high on entry; release it after the
                // last LOAD cycle so the core sees a clean reset per block.
                aes_reset_d = 1'b1;
                if (rst_cnt_q == RC_W'(1)) begin
                    aes_reset_d = 1'b0;
                    to_cnt_d    = '0;
                    state_d     = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RC_W'(1);
                end
            end

            RUN: begin
                // A done seen in the first RUN cycle may be left over from the
                // previous block before reset took effect, so it is ignored.
                if ((to_cnt_q != '0) && aes_done) begin
                    out_data_d  = aes_result;
                    out_valid_d = 1'b1;
                    blk_count_d = blk_count_q + CNT_W'(1);
                    state_d     = OUT;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d       = 1'b1;
                    aes_reset_d = 1'b1;
                    state_d     = ERR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    aes_reset_d = 1'b1;
                    state_d     = key_valid ? IDLE : WAIT_KEY;
                end
            end

            ERR: begin
                aes_reset_d = 1'b1;
                out_valid_d = 1'b0;
                if (err_clear) begin
                    err_d     = 1'b0;
                    aes_key_d = '0;
                    state_d   = WAIT_KEY;
                end
            end

            default: begin
                aes_reset_d = 1'b1;
                state_d     = WAIT_KEY;
            end
        endcase

        // Ready depends only on where the FSM is heading and the key status.
        in_ready_d = (state_d == IDLE) && key_valid;
    end

    // State register with asynchronous clear of every flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_KEY;
            in_ready_q  <= 1'b0;
            aes_reset_q <= 1'b1;
            aes_data_q  <= '0;
            aes_key_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            blk_count_q <= '0;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            aes_reset_q <= aes_reset_d;
            aes_data_q  <= aes_data_d;
            aes_key_q   <= aes_key_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            blk_count_q <= blk_count_d;
            rst_cnt_q   <= rst_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign aes_reset = aes_reset_q;
    assign aes_data  = aes_data_q;
    assign aes_key   = aes_key_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;
    assign blk_count = blk_count_q;

endmodule
